// File: rtl/rf_write_arbiter_pkg.sv
// ============================================================================
// Module   : rf_write_arbiter_pkg
// Brief    : Shared core constants and arbiter state encoding.
// Revision : 1.0
// ============================================================================
`default_nettype none

package rf_write_arbiter_pkg;

    localparam int DataWidth  = 32;
    localparam int NumRegs    = 32;
    localparam int IndexWidth = $clog2(NumRegs);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        PEND  = 2'd1,
        FORCE = 2'd2
    } arb_state_t;

endpackage

`default_nettype wire

// File: rtl/rf_aux_hold.sv
// ============================================================================
// Module   : rf_aux_hold
// Brief    : One-entry aux holding register with valid/ready, drain and drop.
// Revision : 1.0
// ============================================================================
`default_nettype none

module rf_aux_hold #(
    parameter int AddrWidth = 5,
    parameter int DataWidth = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 aux_valid_i,
    input  logic [AddrWidth-1:0] aux_addr_i,
    input  logic [DataWidth-1:0] aux_data_i,
    input  logic                 grant_i,
    input  logic                 drop_i,
    output logic                 aux_ready_o,
    output logic                 load_o,
    output logic                 hold_valid_o,
    output logic [AddrWidth-1:0] hold_addr_o,
    output logic [DataWidth-1:0] hold_data_o
);

    logic                 hold_valid_q;
    logic [AddrWidth-1:0] hold_addr_q;
    logic [DataWidth-1:0] hold_data_q;

    // Ready is forced high during reset so upstream never sees a stall then.
    assign aux_ready_o  = !reset || !hold_valid_q || grant_i;
    assign load_o       = aux_valid_i && aux_ready_o;
    assign hold_valid_o = hold_valid_q;
    assign hold_addr_o  = hold_addr_q;
    assign hold_data_o  = hold_data_q;

    always_ff @(posedge clk) begin
        if (!reset) begin
            hold_valid_q <= 1'b0;
            hold_addr_q  <= '0;
            hold_data_q  <= '0;
        end else if (load_o) begin
            hold_valid_q <= 1'b1;
            hold_addr_q  <= aux_addr_i;
            hold_data_q  <= aux_data_i;
        end else if (grant_i || drop_i) begin
            hold_valid_q <= 1'b0;
        end
    end

endmodule

`default_nettype wire

// File: rtl/rf_write_arbiter.sv
// ============================================================================
// Module   : rf_write_arbiter
// Brief    : Writeback/aux arbiter for the register-file write port.
//            Starvation guard enabled by RF_ARB_STARVE_GUARD_EN.
// Revision : 1.0
// ============================================================================
`default_nettype none

module rf_write_arbiter #(
    parameter int DataWidth  = rf_write_arbiter_pkg::DataWidth,
    parameter int NumRegs    = rf_write_arbiter_pkg::NumRegs,
    parameter int IndexWidth = $clog2(NumRegs),
    parameter int MaxWait    = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  wb_valid,
    input  logic [IndexWidth-1:0] wb_addr,
    input  logic [DataWidth-1:0]  wb_data,
    output logic                  wb_stall,
    input  logic                  aux_valid,
    input  logic [IndexWidth-1:0] aux_addr,
    input  logic [DataWidth-1:0]  aux_data,
    output logic                  aux_ready,
    output logic                  aux_dropped,
    output logic                  rf_writeEn,
    output logic [IndexWidth-1:0] rf_writeAddr,
    output logic [DataWidth-1:0]  rf_writeData
);

    import rf_write_arbiter_pkg::*;

    arb_state_t            state_q;
    logic                  w_hold_valid;
    logic [IndexWidth-1:0] w_hold_addr;
    logic [DataWidth-1:0]  w_hold_data;
    logic                  w_load;
    logic                  w_force;
    logic                  w_wb_grant;
    logic                  w_aux_grant;
    logic                  w_drop;
    logic                  rf_writeEn_q;
    logic [IndexWidth-1:0] rf_writeAddr_q;
    logic [DataWidth-1:0]  rf_writeData_q;
    logic                  aux_dropped_q;

`ifdef RF_ARB_STARVE_GUARD_EN
    logic [3:0] wait_cnt_q;
    assign w_force = (state_q == FORCE);
`else
    logic w_unused_maxwait;
    assign w_unused_maxwait = (MaxWait != 0);
    assign w_force          = 1'b0;
`endif

    assign w_wb_grant  = !w_force && wb_valid;
    assign w_aux_grant = w_hold_valid && (w_force || !wb_valid);
    // A younger writeback to the same non-zero register makes the held entry stale.
    assign w_drop      = (state_q == PEND) && w_wb_grant &&
                         (wb_addr == w_hold_addr) && (w_hold_addr != '0);
    assign wb_stall    = reset && w_force;

    rf_aux_hold #(
        .AddrWidth (IndexWidth),
        .DataWidth (DataWidth)
    ) u_hold (
        .clk          (clk),
        .reset        (reset),
        .aux_valid_i  (aux_valid),
        .aux_addr_i   (aux_addr),
        .aux_data_i   (aux_data),
        .grant_i      (w_aux_grant),
        .drop_i       (w_drop),
        .aux_ready_o  (aux_ready),
        .load_o       (w_load),
        .hold_valid_o (w_hold_valid),
        .hold_addr_o  (w_hold_addr),
        .hold_data_o  (w_hold_data)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q    <= EMPTY;
`ifdef RF_ARB_STARVE_GUARD_EN
            wait_cnt_q <= '0;
`endif
        end else if (w_load) begin
            state_q    <= PEND;
`ifdef RF_ARB_STARVE_GUARD_EN
            wait_cnt_q <= '0;
`endif
        end else if (w_aux_grant || w_drop) begin
            state_q    <= EMPTY;
`ifdef RF_ARB_STARVE_GUARD_EN
            wait_cnt_q <= '0;
        end else if (state_q == PEND) begin
            if (wait_cnt_q == 4'(MaxWait - 1)) begin
                state_q <= FORCE;
            end
            wait_cnt_q <= wait_cnt_q + 4'd1;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            rf_writeEn_q   <= 1'b0;
            rf_writeAddr_q <= '0;
            rf_writeData_q <= '0;
            aux_dropped_q  <= 1'b0;
        end else begin
            aux_dropped_q <= w_drop;
            if (w_wb_grant) begin
                rf_writeEn_q   <= (wb_addr != '0);
                rf_writeAddr_q <= wb_addr;
                rf_writeData_q <= wb_data;
            end else if (w_aux_grant) begin
                rf_writeEn_q   <= (w_hold_addr != '0);
                rf_writeAddr_q <= w_hold_addr;
                rf_writeData_q <= w_hold_data;
            end else begin
                rf_writeEn_q   <= 1'b0;
            end
        end
    end

    assign rf_writeEn   = rf_writeEn_q;
    assign rf_writeAddr = rf_writeAddr_q;
    assign rf_writeData = rf_writeData_q;
    assign aux_dropped  = aux_dropped_q;

endmodule

`default_nettype wire

// File: tb/tb_rf_write_arbiter.sv
// ============================================================================
// Module   : tb_rf_write_arbiter
// Brief    : Scoreboard bench for rf_write_arbiter (guard via RF_ARB_STARVE_GUARD_EN).
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_rf_write_arbiter;

`ifdef RF_ARB_STARVE_GUARD_EN
    localparam bit GUARD = 1'b1;
`else
    localparam bit GUARD = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic        wb_valid;
    logic [4:0]  wb_addr;
    logic [31:0] wb_data;
    logic        wb_stall;
    logic        aux_valid;
    logic [4:0]  aux_addr;
    logic [31:0] aux_data;
    logic        aux_ready;
    logic        aux_dropped;
    logic        rf_writeEn;
    logic [4:0]  rf_writeAddr;
    logic [31:0] rf_writeData;

    int n_checks = 0;
    int n_fail   = 0;
    logic [36:0] exp_q[$];

    rf_write_arbiter #(.MaxWait(4)) dut (
        .clk          (clk),
        .reset        (reset),
        .wb_valid     (wb_valid),
        .wb_addr      (wb_addr),
        .wb_data      (wb_data),
        .wb_stall     (wb_stall),
        .aux_valid    (aux_valid),
        .aux_addr     (aux_addr),
        .aux_data     (aux_data),
        .aux_ready    (aux_ready),
        .aux_dropped  (aux_dropped),
        .rf_writeEn   (rf_writeEn),
        .rf_writeAddr (rf_writeAddr),
        .rf_writeData (rf_writeData)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [4:0] a, input logic [31:0] d);
        exp_q.push_back({a, d});
    endtask

    // Monitor: every port write must match the next scoreboard entry.
    always @(negedge clk) begin
        if (rf_writeEn === 1'b1) begin
            n_checks++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_write: got addr %0d data 0x%0h, expected no write",
                         rf_writeAddr, rf_writeData);
            end else begin
                logic [36:0] e;
                e = exp_q.pop_front();
                if ({rf_writeAddr, rf_writeData} !== e) begin
                    n_fail++;
                    $display("FAIL port_write: got addr %0d data 0x%0h expected addr %0d data 0x%0h",
                             rf_writeAddr, rf_writeData, e[36:32], e[31:0]);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

    initial begin
        int k;
        reset = 1'b0; wb_valid = 1'b0; wb_addr = '0; wb_data = '0;
        aux_valid = 1'b0; aux_addr = '0; aux_data = '0;

        // Reset held two cycles
        @(negedge clk);
        check("reset_aux_ready", 32'(aux_ready), 32'd1);
        check("reset_wb_stall", 32'(wb_stall), 32'd0);
        step(); step();
        @(negedge clk);
        check("reset_writeEn", 32'(rf_writeEn), 32'd0);
        check("reset_writeAddr", 32'(rf_writeAddr), 32'd0);
        check("reset_writeData", rf_writeData, 32'd0);
        check("reset_dropped", 32'(aux_dropped), 32'd0);
        step();
        reset = 1'b1;

        // Plain writeback
        wb_valid = 1'b1; wb_addr = 5'd1; wb_data = 32'h1234_5678;
        push(5'd1, 32'h1234_5678);
        @(negedge clk);
        check("wb_no_stall", 32'(wb_stall), 32'd0);
        step();
        wb_valid = 1'b0;
        step();

        // Aux only: accept t, port in t+2
        aux_valid = 1'b1; aux_addr = 5'd31; aux_data = 32'hDEAD_BEEF;
        push(5'd31, 32'hDEAD_BEEF);
        @(negedge clk);
        check("aux_ready_accept", 32'(aux_ready), 32'd1);
        step();
        aux_valid = 1'b0;
        @(negedge clk);
        check("aux_ready_drain", 32'(aux_ready), 32'd1);
        check("aux_not_early", 32'(rf_writeEn), 32'd0);
        step(); step(); step();

        // Held aux behind two writeback cycles
        aux_valid = 1'b1; aux_addr = 5'd5; aux_data = 32'h0000_0055;
        step();
        aux_valid = 1'b0;
        wb_valid = 1'b1; wb_addr = 5'd7; wb_data = 32'h70;
        push(5'd7, 32'h70);
        @(negedge clk);
        check("aux_ready_blocked", 32'(aux_ready), 32'd0);
        step();
        wb_data = 32'h71;
        push(5'd7, 32'h71);
        step();
        wb_valid = 1'b0;
        push(5'd5, 32'h55);
        step(); step(); step();

        // Continuous writeback with aux held to addr 9
        k = 0;
        for (int i = 0; i < 7; i++) begin
            wb_valid = 1'b1; wb_addr = 5'd10; wb_data = 32'h1000 + 32'(k);
            aux_valid = (i == 0); aux_addr = 5'd9; aux_data = 32'h99;
            if (GUARD && i == 5) push(5'd9, 32'h99);
            else                 push(5'd10, 32'h1000 + 32'(k));
            @(negedge clk);
            check($sformatf("guard_stall_%0d", i), 32'(wb_stall), 32'(GUARD && i == 5));
            step();
            if (!(GUARD && i == 5)) k++;
        end
        wb_valid = 1'b0; aux_valid = 1'b0;
        if (!GUARD) push(5'd9, 32'h99);
        step(); step(); step();

        // Stale drop: writeback to the held address wins
        aux_valid = 1'b1; aux_addr = 5'd3; aux_data = 32'h0000_AAAA;
        step();
        aux_valid = 1'b0;
        wb_valid = 1'b1; wb_addr = 5'd3; wb_data = 32'h0000_BBBB;
        push(5'd3, 32'h0000_BBBB);
        @(negedge clk);
        check("drop_aux_ready", 32'(aux_ready), 32'd0);
        step();
        wb_valid = 1'b0;
        @(negedge clk);
        check("drop_pulse", 32'(aux_dropped), 32'd1);
        step();
        @(negedge clk);
        check("drop_pulse_end", 32'(aux_dropped), 32'd0);
        step(); step();

        // x0 writeback suppressed
        wb_valid = 1'b1; wb_addr = 5'd0; wb_data = 32'hFFFF_FFFF;
        step();
        wb_valid = 1'b0;
        @(negedge clk);
        check("x0_writeEn", 32'(rf_writeEn), 32'd0);
        step();

        // Reset while an aux entry is pending
        aux_valid = 1'b1; aux_addr = 5'd12; aux_data = 32'hC0C0;
        wb_valid = 1'b1; wb_addr = 5'd13; wb_data = 32'h13;
        push(5'd13, 32'h13);
        step();
        aux_valid = 1'b0;
        reset = 1'b0;
        @(negedge clk);
        check("midpend_reset_ready", 32'(aux_ready), 32'd1);
        check("midpend_reset_stall", 32'(wb_stall), 32'd0);
        step();
        reset = 1'b1; wb_valid = 1'b0;
        @(negedge clk);
        check("midpend_aux_ready", 32'(aux_ready), 32'd1);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("midpend_no_drop", 32'(aux_dropped), 32'd0);
            step();
        end

        @(negedge clk);
        check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/rf_write_arbiter.md
# rf_write_arbiter

Shares the single register-file write port (`writeEn`/`writeAddr`/`writeData`) between the pipeline writeback stage and an auxiliary writer: load return, CSR read-back or debug. Writeback has priority. Aux requests wait in a one-entry holding register behind a valid/ready handshake. A starvation guard stalls the pipeline when aux has waited too long. The block sits between the writeback stage and `register_file`, and its registered outputs drive the register-file write port directly.

## Interface
- `DataWidth`, 32, register width
- `NumRegs`, 32, number of architectural registers
- `IndexWidth`, `$clog2(NumRegs)`, register index width
- `MaxWait`, 4, cycles a held aux request may be refused before the guard forces it (1..15)
- `clk`  in  1  clock, all state on rising edge
- `reset`  in  1  synchronous, active-low reset
- `wb_valid`  in  1  writeback wants to write this cycle
- `wb_addr`  in  `IndexWidth`  writeback destination register
- `wb_data`  in  `DataWidth`  writeback data
- `wb_stall`  out  1  writeback refused this cycle; pipeline holds its `wb_*` inputs
- `aux_valid`  in  1  aux request present
- `aux_addr`  in  `IndexWidth`  aux destination register
- `aux_data`  in  `DataWidth`  aux data
- `aux_ready`  out  1  aux request accepted when high together with `aux_valid`
- `aux_dropped`  out  1  one-cycle pulse: held aux entry discarded as stale
- `rf_writeEn`  out  1  to `register_file.writeEn`
- `rf_writeAddr`  out  `IndexWidth`  to `register_file.writeAddr`
- `rf_writeData`  out  `DataWidth`  to `register_file.writeData`

## Operation
- Holding register: `hold_valid`, `hold_addr`, `hold_data`.
- States: EMPTY (`hold_valid`=0), PEND (held, waiting), FORCE (held, guard active).
- Grant rule, evaluated each cycle:
  - FORCE: aux is granted, `wb_stall`=1.
  - Otherwise, if `wb_valid`=1: writeback is granted, `wb_stall`=0.
  - Otherwise, if `hold_valid`=1: aux is granted.
- `aux_ready` = !`hold_valid` || aux granted this cycle. A new request may refill the holding register in the same cycle the old entry drains.
- Transitions:
  - EMPTY→PEND when a request is accepted.
  - PEND→EMPTY on grant, unless it is refilled.
  - PEND→FORCE when `wait_cnt` reaches `MaxWait`.
  - FORCE→EMPTY/PEND unconditionally next cycle, because FORCE always grants.
- `wait_cnt` increments each cycle in PEND without a grant, and clears on grant or reload.
- Stale drop: in PEND, if the writeback is granted with `wb_addr`==`hold_addr` and `hold_addr`≠0, the held entry is discarded. The writeback is younger and wins. `aux_dropped` pulses and the state returns to EMPTY. This never happens in FORCE.
- Register x0:
  - Requests to address 0 are accepted and granted normally.
  - `rf_writeEn` is forced to 0 for address 0; `register_file` ignores x0 anyway.
  - Address-0 requests are never used for stale matching.
- `wb_valid` while `wb_stall`=1 must be held stable by the pipeline. The arbiter does not capture it.

## Timing
- Granted request in cycle t → `rf_writeEn`/`rf_writeAddr`/`rf_writeData` valid in cycle t+1 (registered). `register_file` commits at the end of t+1.
- Aux latency, no contention: accept in t, grant in t+1, port active in t+2.
- `wb_stall` and `aux_ready` are combinational from state and inputs in the same cycle.
- With guard: `wb_stall` is asserted at most 1 cycle in every `MaxWait`+1.
- Reset (`reset`=0 at an edge):
  - State EMPTY, `wait_cnt`=0.
  - `rf_writeEn`=0, `rf_writeAddr`=0, `rf_writeData`=0, `aux_dropped`=0.
  - `wb_stall`=0 and `aux_ready`=1 during and after reset.
  - A reset mid-PEND or mid-FORCE discards the held entry without an `aux_dropped` pulse.

## Configuration
- `RF_ARB_STARVE_GUARD_EN` defined:
  - FORCE state and `wait_cnt` are present; behaviour is as above.
- Undefined:
  - Strict writeback priority; `wb_stall` is tied to 0.
  - FORCE and `wait_cnt` are removed, so aux may wait indefinitely.

## Structure
- The shared core package holds:
  - the `arb_state_t` enum (EMPTY, PEND, FORCE);
  - `DataWidth`, `NumRegs` and `IndexWidth` constants, reused by `register_file`.
- One natural sub-module: `rf_aux_hold`, the one-entry holding register with valid/ready and its drop/drain controls. Arbitration and the output register stay in `rf_write_arbiter`.

## Test plan
- Reset held 2 cycles, then `wb_valid`=1, `wb_addr`=1, `wb_data`=0x12345678 → next cycle `rf_writeEn`=1, `rf_writeAddr`=1, `rf_writeData`=0x12345678; `wb_stall`=0.
- Aux only, `aux_addr`=31, `aux_data`=0xDEADBEEF accepted in t → port shows addr 31 / 0xDEADBEEF in t+2; `aux_ready` stays 1 throughout.
- Aux held for addr 5 while `wb_valid`=1 to addr 7 for 2 cycles → writeback granted both cycles; aux writes addr 5 the cycle after `wb_valid` drops.
- Guard defined, `MaxWait`=4, `wb_valid`=1 continuously, aux held to addr 9 → `wb_stall`=1 for exactly one cycle at the 5th wait cycle; aux written next cycle.
- Aux held addr 3 = 0xAAAA, then writeback addr 3 = 0xBBBB granted → `aux_dropped` pulses; only 0xBBBB is ever written to addr 3.
- Writeback to addr 0 with data 0xFFFF_FFFF → `rf_writeEn`=0 the following cycle. Separately, `reset`=0 while in PEND → EMPTY with no later write.
